uart_tx_7n: RTL



---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_gen.sv | 27 ++
 rtl/uart_tx_7n.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state type and baud divisor helper
package uart_pkg;

  localparam int DATA_BITS = 7;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter, ticks in the last cycle of each period
module uart_baud_gen #(
  parameter int DIV = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (restart_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_7n.sv
// rtl/uart_tx_7n.sv - 7N1/7N2 UART transmitter with one-entry holding register
module uart_tx_7n
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);

  generate
    if (DIV < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
      $error("uart_tx_7n: DIV must be >= 2 and STOP_BITS must be 1 or 2");
    end
  endgenerate

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 restart, tick, handshake, last_stop;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart_i(restart),
    .tick_o   (tick)
  );

  assign in_ready  = !hold_full_q;
  assign handshake = in_valid && in_ready;
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE) || hold_full_q;
  assign tx_done   = last_stop;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_idx_d   = bit_idx_q;
    tx_d        = tx_q;
    restart     = 1'b0;
    last_stop   = 1'b0;
    case (state_q)
      IDLE: begin
        restart = 1'b1;
        tx_d    = 1'b1;
        if (handshake) begin
          state_d = START;
          shift_d = in_data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d   = STOP;
            tx_d      = 1'b1;
            bit_idx_d = '0;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_idx_q == 3'(STOP_BITS - 1)) begin
            last_stop = 1'b1;
            bit_idx_d = '0;
            // Chain straight into the next frame so there is no idle gap
            if (hold_full_q || handshake) begin
              state_d     = START;
              restart     = 1'b1;
              tx_d        = 1'b0;
              shift_d     = hold_full_q ? hold_q : in_data;
              hold_full_d = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (handshake && state_q != IDLE && !last_stop) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_idx_q   <= '0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
    end
  end

endmodule
